// File: rtl/dctlb_pfe_sched_if.sv
// ---------------------------------------------------------------------------
// dctlb_pfe_sched_if
// Bundle of every non-clock/reset signal of the DCTLB prefetch scheduler.
//   pfe_*        prefetcher request channel (valid/retry handshake)
//   ld_busy      core load owns forwarding port 0 this cycle
//   st_busy      core store owns forwarding port 1 this cycle
//   fwd0_*       prefetch slot on forwarding port 0 (valid/retry handshake)
//   fwd1_*       prefetch slot on forwarding port 1 (valid/retry handshake)
//   ld_hold      request to the core to idle its load port next cycle
//   drop_cnt     saturating count of duplicate prefetches dropped
// Modport slave is the scheduler; modport master is its environment.
// ---------------------------------------------------------------------------
interface dctlb_pfe_sched_if #(
  parameter int LADDR_W = 39
);
  logic               pfe_valid;
  logic               pfe_retry;
  logic [LADDR_W-1:0] pfe_laddr;
  logic               pfe_l2;
  logic               ld_busy;
  logic               st_busy;
  logic               fwd0_valid;
  logic               fwd0_retry;
  logic [LADDR_W-1:0] fwd0_laddr;
  logic               fwd0_l2;
  logic               fwd1_valid;
  logic               fwd1_retry;
  logic [LADDR_W-1:0] fwd1_laddr;
  logic               fwd1_l2;
  logic               ld_hold;
  logic [15:0]        drop_cnt;

  modport slave (
    input  pfe_valid, pfe_laddr, pfe_l2, ld_busy, st_busy, fwd0_retry, fwd1_retry,
    output pfe_retry, fwd0_valid, fwd0_laddr, fwd0_l2,
    output fwd1_valid, fwd1_laddr, fwd1_l2, ld_hold, drop_cnt
  );

  modport master (
    output pfe_valid, pfe_laddr, pfe_l2, ld_busy, st_busy, fwd0_retry, fwd1_retry,
    input  pfe_retry, fwd0_valid, fwd0_laddr, fwd0_l2,
    input  fwd1_valid, fwd1_laddr, fwd1_l2, ld_hold, drop_cnt
  );
endinterface

// File: rtl/dctlb_pfe_sched.sv
// ---------------------------------------------------------------------------
// dctlb_pfe_sched
// Queues TLB prefetch requests and slips them onto whichever forwarding port
// the core leaves idle (port 0 preferred, port 1 when only the load port is
// taken). Requests whose page is already queued are dropped and counted.
// If the head waits STARVE_MAX cycles, ld_hold asks the core to idle port 0.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous active-high reset
//   bus    dctlb_pfe_sched_if.slave (request, forwarding and status signals)
// Parameters: DEPTH (power of two, >= 2), STARVE_MAX (>= 1),
//   LADDR_W (>= 13, must match the interface's LADDR_W).
// ---------------------------------------------------------------------------
module dctlb_pfe_sched #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int LADDR_W    = 39
) (
  input  logic                  clk,
  input  logic                  reset,
  dctlb_pfe_sched_if.slave      bus
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int WAIT_W   = $clog2(STARVE_MAX + 1);
  localparam int PAGE_LSB = 12;
  localparam logic [CNT_W-1:0]  OCC_FULL = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_MAX);

  logic [LADDR_W-1:0] mem_laddr_q [DEPTH];
  logic [DEPTH-1:0]   mem_l2_q;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hold_q, hold_d;
  logic [15:0]       drop_q, drop_d;

  logic [PTR_W-1:0]  slot_off_s [DEPTH];
  logic              empty_s, full_s, sel0_s, sel1_s, deq_s, acc_s, dup_s, enq_s;

  // Full is taken from registered occupancy only, so pfe_retry never
  // depends on pfe_valid or on a dequeue happening in the same cycle.
  assign empty_s = (occ_q == {CNT_W{1'b0}});
  assign full_s  = (occ_q == OCC_FULL);

  // Port 0 is preferred; port 1 is used only when the load owns port 0.
  // The choice ignores retry, so a retried slot never falls back.
  assign sel0_s = !empty_s && !bus.ld_busy;
  assign sel1_s = !empty_s &&  bus.ld_busy && !bus.st_busy;
  assign deq_s  = (sel0_s && !bus.fwd0_retry) || (sel1_s && !bus.fwd1_retry);
  assign acc_s  = bus.pfe_valid && !full_s;
  assign enq_s  = acc_s && !dup_s;

  assign bus.pfe_retry  = full_s;
  assign bus.fwd0_valid = sel0_s;
  assign bus.fwd1_valid = sel1_s;
  assign bus.fwd0_laddr = mem_laddr_q[rd_ptr_q];
  assign bus.fwd1_laddr = mem_laddr_q[rd_ptr_q];
  assign bus.fwd0_l2    = mem_l2_q[rd_ptr_q];
  assign bus.fwd1_l2    = mem_l2_q[rd_ptr_q];
  assign bus.ld_hold    = hold_q;
  assign bus.drop_cnt   = drop_q;

  // Duplicate page search over occupied slots, head included even when it
  // leaves this cycle. A slot is occupied when its distance from the read
  // pointer (modulo DEPTH) is below the occupancy.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off_s[i] = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, slot_off_s[i]} < occ_q) &&
          (mem_laddr_q[i][LADDR_W-1:PAGE_LSB] == bus.pfe_laddr[LADDR_W-1:PAGE_LSB])) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
  end

  // Next-state for pointers, occupancy, starvation counter and drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    wait_d   = wait_q;
    drop_d   = drop_q;

    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({enq_s, deq_s})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    if (empty_s || deq_s) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (wait_q != WAIT_LIM) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    if (acc_s && dup_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end

    // Registered alongside wait_cnt so ld_hold mirrors wait_cnt == limit.
    hold_d = (wait_d == WAIT_LIM);
  end

  // Control state with asynchronous reset; reset empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {CNT_W{1'b0}};
      wait_q   <= {WAIT_W{1'b0}};
      hold_q   <= 1'b0;
      drop_q   <= 16'h0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      wait_q   <= wait_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so no reset needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_laddr_q[wr_ptr_q] <= bus.pfe_laddr;
      mem_l2_q[wr_ptr_q]    <= bus.pfe_l2;
    end
  end
endmodule

// File: tb/tb_dctlb_pfe_sched.sv
module tb_dctlb_pfe_sched;
  localparam int DEPTH = 4;
  localparam int SM    = 8;
  localparam int AW    = 39;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dctlb_pfe_sched_if #(.LADDR_W(AW)) bus ();

  dctlb_pfe_sched #(.DEPTH(DEPTH), .STARVE_MAX(SM), .LADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] laddr;
    logic          l2;
  } ent_t;

  // Reference model: a queue of pending prefetches plus plain counters.
  ent_t mq[$];
  int   m_wait;
  int   m_drop;
  bit   m_hold;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] a, input bit l2,
                       input bit lb, input bit sb, input bit r0, input bit r1);
    bus.pfe_valid  = v;
    bus.pfe_laddr  = a;
    bus.pfe_l2     = l2;
    bus.ld_busy    = lb;
    bus.st_busy    = sb;
    bus.fwd0_retry = r0;
    bus.fwd1_retry = r1;
  endtask

  // One clock cycle: compare DUT outputs with the model, then advance model.
  task automatic cycle();
    bit   full, ne, v0, v1, deq, acc, dup;
    ent_t e;
    #1;
    full = (mq.size() == DEPTH);
    ne   = (mq.size() != 0);
    v0   = ne && !bus.ld_busy;
    v1   = ne && bus.ld_busy && !bus.st_busy;
    chk("pfe_retry", bus.pfe_retry, full);
    chk("fwd0_valid", bus.fwd0_valid, v0);
    chk("fwd1_valid", bus.fwd1_valid, v1);
    chk("ld_hold", bus.ld_hold, m_hold);
    chk("drop_cnt", bus.drop_cnt, m_drop);
    if (v0) begin
      chk("fwd0_laddr", bus.fwd0_laddr, mq[0].laddr);
      chk("fwd0_l2", bus.fwd0_l2, mq[0].l2);
    end
    if (v1) begin
      chk("fwd1_laddr", bus.fwd1_laddr, mq[0].laddr);
      chk("fwd1_l2", bus.fwd1_l2, mq[0].l2);
    end
    deq = (v0 && !bus.fwd0_retry) || (v1 && !bus.fwd1_retry);
    acc = bus.pfe_valid && !full;
    dup = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].laddr[AW-1:12] == bus.pfe_laddr[AW-1:12]) dup = 1'b1;
    end
    e.laddr = bus.pfe_laddr;
    e.l2    = bus.pfe_l2;
    @(posedge clk);
    if (deq) void'(mq.pop_front());
    if (acc && !dup) mq.push_back(e);
    if (acc && dup && m_drop < 65535) m_drop++;
    if (!ne || deq) m_wait = 0;
    else if (m_wait < SM) m_wait++;
    m_hold = (m_wait == SM);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    mq.delete();
    m_wait = 0;
    m_drop = 0;
    m_hold = 1'b0;
    chk("rst_pfe_retry", bus.pfe_retry, 1'b0);
    chk("rst_fwd0_valid", bus.fwd0_valid, 1'b0);
    chk("rst_fwd1_valid", bus.fwd1_valid, 1'b0);
    chk("rst_ld_hold", bus.ld_hold, 1'b0);
    chk("rst_drop_cnt", bus.drop_cnt, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    checks = 0;
    errors = 0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // Idle ports: entry written in cycle 0 appears on port 0 in cycle 1.
    drive(1'b1, 39'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("bypass_fwd0", bus.fwd0_valid, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("idle_fwd0_valid", bus.fwd0_valid, 1'b1);
    chk("idle_fwd0_laddr", bus.fwd0_laddr, 39'h1000);
    chk("idle_fwd1_valid", bus.fwd1_valid, 1'b0);
    cycle();

    // Load busy: head goes to port 1 and is held while port 1 retries.
    drive(1'b1, 39'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("p1_fwd1_valid", bus.fwd1_valid, 1'b1);
      chk("p1_fwd1_laddr", bus.fwd1_laddr, 39'h2000);
      chk("p1_fwd0_valid", bus.fwd0_valid, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("p1_release", bus.fwd1_laddr, 39'h2000);
    cycle();

    // Fill with four distinct pages, then one port-0 transfer frees a slot.
    for (int k = 0; k < 4; k++) begin
      a = 39'h4000 + 39'(k) * 39'h1000;
      drive(1'b1, a, k[0], 1'b1, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 39'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("full_retry", bus.pfe_retry, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("full_retry_deq", bus.pfe_retry, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("unfull_retry", bus.pfe_retry, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
    end

    // Duplicate page dropped and counted; queue still holds only one entry.
    drive(1'b1, 39'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 39'h3ABC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("dup_drop_cnt", bus.drop_cnt, 16'h0001);
    chk("dup_head", bus.fwd0_laddr, 39'h3000);
    cycle();
    #1 chk("dup_occ_one", bus.fwd0_valid, 1'b0);

    // Starvation: ld_hold rises after SM stalled cycles, drops after dequeue.
    drive(1'b1, 39'h9000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < SM - 1; k++) cycle();
    #1 chk("hold_not_yet", bus.ld_hold, 1'b0);
    cycle();
    #1 chk("hold_up", bus.ld_hold, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("hold_deq_fwd0", bus.fwd0_valid, 1'b1);
    cycle();
    #1 chk("hold_down", bus.ld_hold, 1'b0);
    cycle();

    // Reset mid-operation discards the queue; first post-reset enqueue works.
    for (int k = 0; k < 3; k++) begin
      a = 39'hB000 + 39'(k) * 39'h1000;
      drive(1'b1, a, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    do_reset();
    drive(1'b1, 39'hA000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("post_rst_stale", bus.fwd0_valid, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("post_rst_first", bus.fwd0_laddr, 39'hA000);
    cycle();

    // Randomized traffic against the model; few pages to provoke duplicates.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) a = 39'({$urandom, $urandom});
      else a = {24'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
      drive(1'($urandom_range(0, 2) != 0), a, 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      cycle();
      if (k == 300) begin
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dctlb_pfe_sched.md
DCTLB_PFE_SCHED -- requirements
Module: dctlb_pfe_sched

Interface
REQ-001 Parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-002 Parameter STARVE_MAX, default 8: head-wait cycles before ld_hold asserts; at least 1.
REQ-003 Parameter LADDR_W, default 39: logical address width; at least 13.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pfe_valid  in  1  prefetcher request valid.
REQ-007 pfe_retry  out  1  queue cannot accept.
REQ-008 pfe_laddr  in  LADDR_W  prefetch logical address.
REQ-009 pfe_l2  in  1  prefetch targets L2 only.
REQ-010 ld_busy  in  1  core load occupies fwd port 0 this cycle.
REQ-011 st_busy  in  1  core store occupies fwd port 1 this cycle.
REQ-012 fwd0_valid / fwd0_retry / fwd0_laddr / fwd0_l2  out / in / out / out  1 / 1 / LADDR_W / 1  prefetch slot on port 0.
REQ-013 fwd1_valid / fwd1_retry / fwd1_laddr / fwd1_l2  out / in / out / out  1 / 1 / LADDR_W / 1  prefetch slot on port 1.
REQ-014 ld_hold  out  1  asks core to idle load port next cycle.
REQ-015 drop_cnt  out  16  saturating count of duplicate prefetches dropped.

Function
REQ-016 A transfer occurs on any channel when its valid is 1 and its retry is 0 in the same cycle.
REQ-017 The block SHALL hold a FIFO of DEPTH entries {laddr, l2}; pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH+1).
REQ-018 pfe_retry SHALL equal (occupancy == DEPTH) from registered state only, independent of pfe_valid and of any same-cycle dequeue.
REQ-019 Duplicate: incoming pfe_laddr[LADDR_W-1:12] equals page bits of any occupied entry, including the head being dequeued that cycle.
REQ-020 Accepted non-duplicate request SHALL be written at the tail; accepted duplicate SHALL be discarded and drop_cnt incremented, holding at 0xFFFF.
REQ-021 No bypass: an entry written in cycle N is first visible on a fwd port in cycle N+1.
REQ-022 With queue non-empty and ld_busy = 0, head SHALL be presented on port 0 only.
REQ-023 With queue non-empty, ld_busy = 1, st_busy = 0, head SHALL be presented on port 1 only.
REQ-024 fwd0_valid and fwd1_valid SHALL never both be 1; both 0 when empty or both busy.
REQ-025 fwdX_laddr and fwdX_l2 SHALL carry head fields whenever fwdX_valid = 1; don't-care otherwise.
REQ-026 Selected port retry = 1: no fallback to the other port that cycle; head remains.
REQ-027 Head dequeues on transfer on the selected port; at most one dequeue per cycle.
REQ-028 Same-cycle enqueue and dequeue when not full SHALL leave occupancy unchanged.
REQ-029 wait_cnt increments each cycle the queue is non-empty without a dequeue, saturating at STARVE_MAX; clears on dequeue or when empty.
REQ-030 ld_hold SHALL be registered, 1 exactly when wait_cnt == STARVE_MAX, and drop the cycle after the head dequeues.

Reset
REQ-031 Reset assertion SHALL immediately clear pointers, occupancy, wait_cnt, drop_cnt, and ld_hold.
REQ-032 During and after reset, outputs are pfe_retry = 0, fwd0_valid = 0, fwd1_valid = 0, ld_hold = 0, drop_cnt = 0.
REQ-033 Reset mid-operation discards queued entries; none is presented after reset release.
REQ-034 After reset deassertion, first enqueue is accepted on the first rising edge.

Verification
REQ-035 Bench: idle ports; enqueue laddr 0x1000 in cycle 0 -> fwd0_valid = 1 with laddr 0x1000 in cycle 1; fwd1_valid = 0.
REQ-036 Bench: ld_busy = 1, st_busy = 0, one entry 0x2000 -> fwd1_valid = 1, laddr 0x2000; fwd1_retry = 1 for 2 cycles -> entry held, no fwd0.
REQ-037 Bench: 4 distinct pages enqueued, no dequeue -> pfe_retry = 1; one port-0 transfer -> pfe_retry = 0 next cycle.
REQ-038 Bench: queue holds 0x3000; enqueue 0x3ABC -> dropped, drop_cnt 0 to 1, occupancy stays 1.
REQ-039 Bench: ld_busy = st_busy = 1 with one entry, STARVE_MAX = 8 -> ld_hold rises after 8 stalled cycles; ld_busy = 0 -> transfer on port 0, ld_hold = 0 next cycle.
REQ-040 Bench: reset pulse with 3 entries queued -> all valids 0 immediately; no stale entry issued after release.
